amp_fault_latch: RTL and testbench

- Per-axis amplifier enable controller directly downstream of the current-error safety checker.
- Consumes that block's amp_disable level plus a motor-supply-good flag, and latches any fault.
- Holds the amplifier off until the host issues an explicit clear, then enforces a hold-off period.
- Re-enables only on a fresh host enable request. Outputs drive the amplifier enable pin and the status register bits.

---
 rtl/amp_fault_latch_pkg.sv | 24 ++
 rtl/amp_fault_filter.sv | 36 +++
 rtl/amp_fault_latch.sv | 150 +++++++++++++++
 tb/tb_amp_fault_latch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_fault_latch_pkg.sv
// Shared definitions for the amplifier fault latch: state encoding,
// fault_cause bit positions and the default hold-off length.
package amp_fault_latch_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENABLED  = 2'd1,
        ST_FAULT    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } amp_state_e;

    // Bit positions inside fault_cause.
    localparam int CAUSE_CUR = 0;
    localparam int CAUSE_MV  = 1;

    // About 100 us at 49.152 MHz.
    localparam int HOLDOFF_CYCLES_DEF = 4915;

    // Width of a down/up counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amp_fault_filter.sv
// Run-length glitch filter on the raw amp_disable level: the fault is
// accepted only once FILTER_LEN consecutive high samples have been seen,
// and any low sample drops it again immediately.
module amp_fault_filter
    import amp_fault_latch_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic fault_o
);

    localparam int            RW      = cnt_width(FILTER_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN - 1);

    // Number of consecutive high samples before the current one, saturating.
    logic [RW-1:0] run_q;

    // Count the current high run; any low sample restarts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= '0;
        end else if (!raw_i) begin
            run_q <= '0;
        end else if (run_q != RUN_MAX) begin
            run_q <= run_q + 1'b1;
        end
    end

    // The sample that completes the run is itself accepted, so the
    // latch trips on the FILTER_LEN-th sampling edge.
    assign fault_o = raw_i & (run_q == RUN_MAX);

endmodule

// File: rtl/amp_fault_latch.sv
// Per-axis amplifier enable controller. Latches current-error and
// supply-loss faults, holds the amplifier off until the host clears,
// waits out a hold-off period, then needs a fresh enable request edge.
// Optional glitch filter on amp_disable_in: define AMP_FAULT_FILTER_EN.
module amp_fault_latch
    import amp_fault_latch_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
    parameter int COUNT_W        = 8,
    parameter int FILTER_LEN     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               amp_disable_in,
    input  logic               mv_good,
    input  logic               enable_req,
    input  logic               fault_clear,
    input  logic               count_clear,
    output logic               amp_enable,
    output logic               fault_latched,
    output logic [1:0]         fault_cause,
    output logic [COUNT_W-1:0] fault_count,
    output logic [1:0]         state
);

    localparam int            HW        = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    if (HOLDOFF_CYCLES < 1 || FILTER_LEN < 1) begin : g_param_check
        $error("amp_fault_latch: HOLDOFF_CYCLES and FILTER_LEN must be >= 1");
    end

    amp_state_e         state_q;
    logic               amp_enable_q;
    logic               fault_latched_q;
    logic [1:0]         fault_cause_q;
    logic [COUNT_W-1:0] fault_count_q;
    logic [COUNT_W-1:0] fault_count_d;
    logic [HW-1:0]      hold_q;
    logic               req_d_q;

    logic       fault_in;
    logic       fault_now;
    logic       req_rise;
    logic       fault_entry;
    logic [1:0] cause_now;

`ifdef AMP_FAULT_FILTER_EN
    amp_fault_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_i   (clk),
        .rst_i   (reset),
        .raw_i   (amp_disable_in),
        .fault_o (fault_in)
    );
`else
    assign fault_in = amp_disable_in;
`endif

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fault_now             = fault_in | ~mv_good;
    assign req_rise              = enable_req & ~req_d_q;
    assign cause_now[CAUSE_CUR]  = fault_in;
    assign cause_now[CAUSE_MV]   = ~mv_good;
    assign fault_entry           = fault_now &
                                   ((state_q == ST_ENABLED) || (state_q == ST_HOLDOFF));

    // Fault counter next value: a clear coinciding with an entry leaves 1.
    always_comb begin
        fault_count_d = count_clear ? '0 : fault_count_q;
        if (fault_entry) begin
            fault_count_d = sat_inc(fault_count_d);
        end
    end

    // Previous enable_req level; resets high so a held request is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d_q <= 1'b1;
        end else begin
            req_d_q <= enable_req;
        end
    end

    // Main FSM; outputs are updated on the same edge as the transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_DISABLED;
            amp_enable_q    <= 1'b0;
            fault_latched_q <= 1'b0;
            fault_cause_q   <= '0;
            fault_count_q   <= '0;
            hold_q          <= '0;
        end else begin
            fault_count_q <= fault_count_d;
            case (state_q)
                ST_DISABLED: begin
                    if (req_rise & ~fault_in & mv_good) begin
                        state_q      <= ST_ENABLED;
                        amp_enable_q <= 1'b1;
                    end
                end
                ST_ENABLED: begin
                    if (fault_now) begin
                        state_q         <= ST_FAULT;
                        amp_enable_q    <= 1'b0;
                        fault_latched_q <= 1'b1;
                        fault_cause_q   <= fault_cause_q | cause_now;
                    end else if (!enable_req) begin
                        state_q      <= ST_DISABLED;
                        amp_enable_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    // A clear while the fault persists is dropped, not queued.
                    if (fault_clear & ~fault_now) begin
                        state_q <= ST_HOLDOFF;
                        hold_q  <= HOLD_LOAD;
                    end
                end
                ST_HOLDOFF: begin
                    if (fault_now) begin
                        state_q       <= ST_FAULT;
                        fault_cause_q <= fault_cause_q | cause_now;
                    end else if (hold_q == '0) begin
                        state_q         <= ST_DISABLED;
                        fault_latched_q <= 1'b0;
                        fault_cause_q   <= '0;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_DISABLED;
                end
            endcase
        end
    end

    assign amp_enable    = amp_enable_q;
    assign fault_latched = fault_latched_q;
    assign fault_cause   = fault_cause_q;
    assign fault_count   = fault_count_q;
    assign state         = state_q;

endmodule

// File: tb/tb_amp_fault_latch.sv
// Testbench for amp_fault_latch: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_amp_fault_latch;

    localparam int HOLD  = 8;
    localparam int CW    = 8;
    localparam int FILT  = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int S_DIS  = 0;
    localparam int S_EN   = 1;
    localparam int S_FLT  = 2;
    localparam int S_HOLD = 3;

    logic          clk;
    logic          reset;
    logic          dis, mv, req, fclr, cclr;
    logic          amp_enable, fault_latched;
    logic [1:0]    fault_cause, state;
    logic [CW-1:0] fault_count;

    int checks = 0;
    int errors = 0;

    amp_fault_latch #(
        .HOLDOFF_CYCLES (HOLD),
        .COUNT_W        (CW),
        .FILTER_LEN     (FILT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .amp_disable_in (dis),
        .mv_good        (mv),
        .enable_req     (req),
        .fault_clear    (fclr),
        .count_clear    (cclr),
        .amp_enable     (amp_enable),
        .fault_latched  (fault_latched),
        .fault_cause    (fault_cause),
        .fault_count    (fault_count),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    int         m_st;
    logic [1:0] m_cause;
    int         m_cnt;
    int         m_elapsed;
    bit         m_req_prev;
    int         m_run;

    task automatic model_reset();
        m_st       = S_DIS;
        m_cause    = 2'b00;
        m_cnt      = 0;
        m_elapsed  = 0;
        m_req_prev = 1'b1;
        m_run      = 0;
    endtask

    task automatic model_step();
        bit fin, bad, rise, entered;
`ifdef AMP_FAULT_FILTER_EN
        fin   = dis && (m_run + 1 >= FILT);
        m_run = dis ? m_run + 1 : 0;
        if (m_run > FILT) m_run = FILT;
`else
        fin = dis;
`endif
        bad        = fin || !mv;
        rise       = req && !m_req_prev;
        m_req_prev = req;
        entered    = 1'b0;
        case (m_st)
            S_DIS: if (rise && !fin && mv) m_st = S_EN;
            S_EN: begin
                if (bad) begin
                    m_st    = S_FLT;
                    m_cause = m_cause | {!mv, fin};
                    entered = 1'b1;
                end else if (!req) begin
                    m_st = S_DIS;
                end
            end
            S_FLT: begin
                if (fclr && !bad) begin
                    m_st      = S_HOLD;
                    m_elapsed = 1;
                end
            end
            default: begin
                if (bad) begin
                    m_st    = S_FLT;
                    m_cause = m_cause | {!mv, fin};
                    entered = 1'b1;
                end else if (m_elapsed == HOLD) begin
                    m_st    = S_DIS;
                    m_cause = 2'b00;
                end else begin
                    m_elapsed++;
                end
            end
        endcase
        if (cclr) m_cnt = 0;
        if (entered && m_cnt < CMAX) m_cnt++;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"},   32'(state),         32'(m_st));
        chk({tag, ".en"},      32'(amp_enable),    32'(m_st == S_EN));
        chk({tag, ".latched"}, 32'(fault_latched), 32'(m_st >= S_FLT));
        chk({tag, ".cause"},   32'(fault_cause),   32'(m_cause));
        chk({tag, ".count"},   32'(fault_count),   32'(m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d, input logic m, input logic r,
                         input logic fc, input logic cc);
        dis = d; mv = m; req = r; fclr = fc; cclr = cc;
    endtask

    // Reset pulse inside one clock period, proving it acts asynchronously.
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".state"},   32'(state),         32'd0);
        chk({tag, ".en"},      32'(amp_enable),    32'd0);
        chk({tag, ".latched"}, 32'(fault_latched), 32'd0);
        chk({tag, ".cause"},   32'(fault_cause),   32'd0);
        chk({tag, ".count"},   32'(fault_count),   32'd0);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic       d, m, r, fc, cc;
        int         rep;
        logic [1:0] st;
        logic       en;
        logic [1:0] cause;
        int         cnt;
    } vec_t;

    function automatic vec_t v(input logic d, input logic m, input logic r,
                               input logic fc, input logic cc, input int rep,
                               input logic [1:0] st, input logic en,
                               input logic [1:0] cause, input int cnt);
        vec_t x;
        x.d = d; x.m = m; x.r = r; x.fc = fc; x.cc = cc; x.rep = rep;
        x.st = st; x.en = en; x.cause = cause; x.cnt = cnt;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state",   32'(state),         32'd0);
        chk("rst.en",      32'(amp_enable),    32'd0);
        chk("rst.latched", 32'(fault_latched), 32'd0);
        chk("rst.cause",   32'(fault_cause),   32'd0);
        chk("rst.count",   32'(fault_count),   32'd0);
        reset = 1'b0;

`ifndef AMP_FAULT_FILTER_EN
        //          d  m  r fc cc rep  st en cause cnt
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 0, 0, 0, 0)); // held request: no enable
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1, 0, 0)); // rising edge enables
        tbl.push_back(v(1, 1, 1, 0, 0, 1, 2, 0, 1, 1)); // one-cycle current fault
        tbl.push_back(v(0, 1, 1, 0, 0, 3, 2, 0, 1, 1)); // stays latched
        tbl.push_back(v(1, 1, 1, 1, 0, 1, 2, 0, 1, 1)); // clear while fault present
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 2, 0, 1, 1)); // no queued clear
        tbl.push_back(v(0, 1, 1, 1, 0, 1, 3, 0, 1, 1)); // hold-off cycle 1
        tbl.push_back(v(0, 1, 1, 0, 0, 7, 3, 0, 1, 1)); // hold-off cycle 8
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 0, 0, 0, 1)); // back to disabled
        tbl.push_back(v(0, 1, 1, 0, 0, 2, 0, 0, 0, 1)); // level request ignored
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 0, 1, 1, 1, 0, 1)); // clear in ENABLED ignored
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 1)); // request drop disables
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 2, 0, 2, 2)); // supply loss
        tbl.push_back(v(0, 0, 1, 1, 0, 1, 2, 0, 2, 2)); // clear while supply bad
        tbl.push_back(v(0, 1, 1, 1, 0, 1, 3, 0, 2, 2)); // hold-off cycle 1
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 3, 0, 2, 2)); // hold-off cycle 2
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 2, 0, 2, 3)); // re-fault at cycle 3
        tbl.push_back(v(0, 1, 1, 1, 0, 1, 3, 0, 2, 3));
        tbl.push_back(v(0, 1, 1, 0, 0, 7, 3, 0, 2, 3));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1, 0, 3));
        tbl.push_back(v(1, 1, 0, 0, 0, 1, 2, 0, 1, 4)); // fault beats request drop
        tbl.push_back(v(0, 1, 0, 1, 0, 1, 3, 0, 1, 4));
        tbl.push_back(v(0, 1, 0, 0, 0, 7, 3, 0, 1, 4));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 4));
        tbl.push_back(v(1, 1, 1, 0, 0, 1, 0, 0, 0, 4)); // edge with fault present
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 4));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1, 0, 4));
        tbl.push_back(v(1, 1, 1, 0, 1, 1, 2, 0, 1, 1)); // count clear + entry
        tbl.push_back(v(0, 1, 1, 0, 1, 1, 2, 0, 1, 0)); // count clear alone

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].d, tbl[i].m, tbl[i].r, tbl[i].fc, tbl[i].cc);
            repeat (tbl[i].rep) tick();
            chk($sformatf("vec%0d.state", i),   32'(state),         32'(tbl[i].st));
            chk($sformatf("vec%0d.en", i),      32'(amp_enable),    32'(tbl[i].en));
            chk($sformatf("vec%0d.latched", i), 32'(fault_latched), 32'(tbl[i].st >= 2'd2));
            chk($sformatf("vec%0d.cause", i),   32'(fault_cause),   32'(tbl[i].cause));
            chk($sformatf("vec%0d.count", i),   32'(fault_count),   32'(tbl[i].cnt));
        end
`endif

        // Reach FAULT via supply loss and zero the counter.
        drive(0, 1, 0, 0, 0); tick(); check_model("prep0");
        drive(0, 1, 1, 0, 0); tick(); check_model("prep1");
        drive(0, 0, 1, 0, 0); tick(); check_model("prep2");
        drive(0, 0, 1, 0, 1); tick(); check_model("prep3");
        chk("prep.state", 32'(state),       32'd2);
        chk("prep.count", 32'(fault_count), 32'd0);

        // 300 fault entries by re-faulting during hold-off.
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 1, 1, 0); tick(); check_model("sat.clr");
            drive(0, 0, 1, 0, 0); tick(); check_model("sat.flt");
        end
        chk("sat.count", 32'(fault_count), 32'd255);
        chk("sat.state", 32'(state),       32'd2);

        // Reset in the middle of hold-off.
        drive(0, 1, 1, 1, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        chk("midhold.state", 32'(state), 32'd3);
        async_reset_pulse("rst_hold");

        // Reset in the middle of a latched fault.
        drive(0, 1, 0, 0, 0); tick(); check_model("mf0");
        drive(0, 1, 1, 0, 0); tick(); check_model("mf1");
        drive(0, 0, 1, 0, 0); tick(); check_model("mf2");
        chk("midfault.state", 32'(state), 32'd2);
        async_reset_pulse("rst_fault");

`ifdef AMP_FAULT_FILTER_EN
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        chk("filt.en", 32'(state), 32'd1);
        drive(1, 1, 1, 0, 0);
        repeat (3) tick();
        chk("filt.3hi", 32'(state), 32'd1);
        drive(0, 1, 1, 0, 0); tick();
        chk("filt.3pulse", 32'(state), 32'd1);
        drive(1, 1, 1, 0, 0);
        repeat (3) tick();
        chk("filt.4a", 32'(amp_enable), 32'd1);
        tick();
        chk("filt.4b.en",    32'(amp_enable),  32'd0);
        chk("filt.4b.state", 32'(state),       32'd2);
        chk("filt.4b.cause", 32'(fault_cause), 32'd1);
        check_model("filt");
`endif

        // Randomized traffic against the model.
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            dis  = ($urandom_range(0, 9) == 0);
            mv   = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) req = ~req;
            fclr = ($urandom_range(0, 3) == 0);
            cclr = ($urandom_range(0, 31) == 0);
            tick();
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
